mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Request arbiter and latency model in front of ram_memory. It takes line-sized (128-bit) read requests from
//  the I-cache and read/write requests from the D-cache. It serialises them onto the single RAM port with a
//  round-robin grant and holds each access for LATENCY cycles, which models main-memory delay.
//  It drives ram_memory's data_requested/where_to_write/data_to_write/write_to_mem and captures data_returned.
// PARAMETERS
//  LATENCY  5    cycles an access occupies the RAM port (>=1)
//  ADDR_W   26   line-address width (matches ram_memory)
//  LINE_W   128  line width in bits
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-high; shared with ram_memory
//  ic_req    in   1       I-cache read request, level, held until ic_ready
//  ic_addr   in   ADDR_W  I-cache line address
//  ic_ready  out  1       one-cycle pulse: ic_rdata valid
//  ic_rdata  out  LINE_W  I-cache read line, held until the next I-cache completion
//  dc_req    in   1       D-cache request, level, held until dc_ready
//  dc_we     in   1       1=write line, 0=read line
//  dc_addr   in   ADDR_W  D-cache line address
//  dc_wdata  in   LINE_W  D-cache write line
//  dc_ready  out  1       one-cycle pulse: D-cache access done (dc_rdata valid if read)
//  dc_rdata  out  LINE_W  D-cache read line, held until the next D-cache read completion
//  mem_addr  out  ADDR_W  -> ram_memory.data_requested
//  mem_waddr out  ADDR_W  -> ram_memory.where_to_write
//  mem_wdata out  LINE_W  -> ram_memory.data_to_write
//  mem_we    out  1       -> ram_memory.write_to_mem
//  mem_rdata in   LINE_W  <- ram_memory.data_returned (combinational)
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, last_grant=IC (so DC wins the first tie). All outputs are 0.
//   In-flight access is aborted: no mem_we, no ready pulse, no rdata update.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: requests sampled here only. If only one req is high, grant it.
//   If both are high, grant the port not in last_grant; update last_grant.
//   On grant, latch addr, we (0 for IC), wdata and owner; load cnt=LATENCY-1; go to BUSY.
//   No req: stay in IDLE with mem_* outputs 0.
//  BUSY: mem_addr and mem_waddr = latched addr; mem_wdata = latched wdata; cnt decrements each cycle.
//   Lasts exactly LATENCY cycles. In the last BUSY cycle (cnt==0):
//   - write: mem_we=1 for that single cycle only.
//   - read: mem_rdata is captured into owner's rdata reg at the exiting edge.
//  RESP: owner's ready=1 for exactly one cycle; mem_we=0; next state is IDLE. The other ready stays 0.
//  Timing: req sampled in IDLE at cycle 0 gives ready at cycle LATENCY+1, and the next grant is sampled at LATENCY+2.
//  Requester drops req on the edge where it samples ready=1. A req still high in IDLE is treated as a new request.
//  Changes to addr/wdata/we after grant are ignored. A req arriving during BUSY/RESP waits for IDLE.
//  A DC write never alters dc_rdata. ic_ready and dc_ready are never high in the same cycle.
//  At most one mem_we pulse per write grant.
// TESTING
//  1 reset; ic_req=1 ic_addr=0; mem_rdata=128'h0A0E0000_18A51800_00330002_0801020A -> mem_addr=0 cycles 1-5;
//    ic_ready=1 only at cycle 6; ic_rdata holds that value afterwards
//  2 dc_req=1 dc_we=1 dc_addr=3 dc_wdata=128'hA5A5...A5 -> mem_we=1 only at cycle 5 with mem_waddr=3;
//    dc_ready at 6; dc_rdata stays 0; a following read of addr 3 returns the A5 line
//  3 ic_req and dc_req both rise at cycle 0 after reset -> DC granted, dc_ready at 6;
//    IC granted at 7, ic_ready at 13; no overlap of ready pulses
//  4 both reqs held continuously (re-raised after each ready) -> grants alternate DC,IC,DC,IC; no starvation
//  5 DC write granted at 0, reset asserted at cycle 3 for 1 cycle -> mem_we never 1, dc_ready never 1,
//    all outputs 0 immediately; new IC req accepted normally after release
//  6 LATENCY=1 build: ic_req at 0 -> single BUSY cycle 1, ic_ready at cycle 2

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D-cache arbiter onto one RAM port, holding each access for LATENCY cycles.
module mem_arbiter #(
  parameter int LATENCY = 5,
  parameter int ADDR_W  = 26,
  parameter int LINE_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [LINE_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int CW = $clog2(LATENCY + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic last_dc, owner_dc, lat_we, grant_dc, any_req, last_busy;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  assign any_req   = ic_req || dc_req;
  // DC wins a tie unless it was the previous tie winner
  assign grant_dc  = dc_req && (!ic_req || !last_dc);
  assign last_busy = state == BUSY && cnt == '0;
  always_comb begin
    state_nx  = state == IDLE ? (any_req ? BUSY : IDLE) : state == BUSY ? (last_busy ? RESP : BUSY) : IDLE;
    mem_addr  = state == BUSY ? lat_addr : '0;
    mem_waddr = state == BUSY ? lat_addr : '0;
    mem_wdata = state == BUSY ? lat_wdata : '0;
    mem_we    = last_busy && lat_we;
    ic_ready  = state == RESP && !owner_dc;
    dc_ready  = state == RESP && owner_dc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dc   <= 1'b0;
      owner_dc  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        owner_dc  <= grant_dc;
        lat_addr  <= grant_dc ? dc_addr : ic_addr;
        lat_we    <= grant_dc && dc_we;
        lat_wdata <= grant_dc ? dc_wdata : '0;
        cnt       <= CW'(LATENCY - 1);
        if (ic_req && dc_req) last_dc <= grant_dc;
      end else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
      if (last_busy && !lat_we && owner_dc) dc_rdata <= mem_rdata;
      if (last_busy && !lat_we && !owner_dc) ic_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, latency, write pulse, async abort and LATENCY=1.
module tb_mem_arbiter;
  localparam logic [127:0] K   = 128'h0A0E0000_18A51800_00330002_0801020A;
  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] K1  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  logic clk, reset;
  logic ic_req, ic_ready, dc_req, dc_we, dc_ready, mem_we;
  logic [25:0] ic_addr, dc_addr, mem_addr, mem_waddr;
  logic [127:0] ic_rdata, dc_wdata, dc_rdata, mem_wdata, mem_rdata;
  logic ic_req1, ic_ready1, dc_ready1, mem_we1;
  logic [25:0] ic_addr1, mem_addr1, mem_waddr1;
  logic [127:0] ic_rdata1, dc_rdata1, mem_wdata1;
  logic [127:0] ram [0:15];
  int total = 0, passed = 0;

  mem_arbiter u_dut (
    .clk(clk), .reset(reset), .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_ready(dc_ready),
    .dc_rdata(dc_rdata), .mem_addr(mem_addr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );
  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_ready(ic_ready1), .ic_rdata(ic_rdata1),
    .dc_req(1'b0), .dc_we(1'b0), .dc_addr(26'd0), .dc_wdata(128'd0), .dc_ready(dc_ready1),
    .dc_rdata(dc_rdata1), .mem_addr(mem_addr1), .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1),
    .mem_we(mem_we1), .mem_rdata(K1)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  assign mem_rdata = ram[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) ram[mem_waddr[3:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  // issue one access at the current IDLE cycle and check cycles 1..7
  task automatic run(input logic idc, input logic we, input logic [25:0] a, input logic [127:0] d);
    if (idc) begin dc_req = 1; dc_we = we; dc_addr = a; dc_wdata = d; end
    else begin ic_req = 1; ic_addr = a; end
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 2) begin dc_addr = '1; dc_wdata = '0; ic_addr = '1; end
      chk("mem_addr", mem_addr, c <= 5 ? a : 26'd0);
      chk("mem_we", mem_we, idc && we && c == 5);
      chk("ic_ready", ic_ready, !idc && c == 6);
      chk("dc_ready", dc_ready, idc && c == 6);
      if (c == 5 && we) begin
        chk("mem_waddr", mem_waddr, a);
        chk("mem_wdata", mem_wdata, d);
      end
      if (c == 6) begin ic_req = 0; dc_req = 0; end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = {8{16'(i * 257)}};
    ram[0] = K;
    reset = 1; ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = 0; dc_addr = 0; dc_wdata = 0;
    ic_req1 = 0; ic_addr1 = 0;
    step(); step();
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst readys", {ic_ready, dc_ready, ic_ready1}, 0);
    chk("rst ic_rdata", ic_rdata, 0);
    chk("rst dc_rdata", dc_rdata, 0);
    reset = 0;
    run(0, 0, 26'd0, '0);
    chk("t1 ic_rdata", ic_rdata, K);
    run(1, 1, 26'd3, A5);
    chk("t2 dc_rdata after write", dc_rdata, 0);
    chk("t2 ram[3]", ram[3], A5);
    run(1, 0, 26'd3, '0);
    chk("t2 dc_rdata read", dc_rdata, A5);
    chk("t2 ic_rdata held", ic_rdata, K);
    pulse_reset();
    ic_req = 1; ic_addr = 1; dc_req = 1; dc_we = 0; dc_addr = 2;
    for (int c = 1; c <= 14; c++) begin
      step();
      chk("t3 dc_ready", dc_ready, c == 6);
      chk("t3 ic_ready", ic_ready, c == 13);
      if (c == 1) chk("t3 dc grant", mem_addr, 2);
      if (c == 8) chk("t3 ic grant", mem_addr, 1);
      if (c == 6) dc_req = 0;
      if (c == 13) ic_req = 0;
    end
    chk("t3 dc_rdata", dc_rdata, ram[2]);
    chk("t3 ic_rdata", ic_rdata, ram[1]);
    pulse_reset();
    ic_req = 1; ic_addr = 4; dc_req = 1; dc_we = 0; dc_addr = 6;
    for (int c = 1; c <= 28; c++) begin
      step();
      chk("t4 dc_ready", dc_ready, c == 6 || c == 20);
      chk("t4 ic_ready", ic_ready, c == 13 || c == 27);
      if (c == 1 || c == 15) chk("t4 dc grant", mem_addr, 6);
      if (c == 8 || c == 22) chk("t4 ic grant", mem_addr, 4);
      if (c == 27) begin ic_req = 0; dc_req = 0; end
    end
    pulse_reset();
    dc_req = 1; dc_we = 1; dc_addr = 5; dc_wdata = A5;
    step();
    chk("t5 busy addr", mem_addr, 5);
    step();
    step();
    reset = 1; dc_req = 0;
    #1;
    chk("t5 abort mem_addr", mem_addr, 0);
    chk("t5 abort mem_waddr", mem_waddr, 0);
    chk("t5 abort mem_wdata", mem_wdata, 0);
    chk("t5 abort we/ready", {mem_we, dc_ready, ic_ready}, 0);
    step();
    reset = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("t5 no we/ready", {mem_we, dc_ready}, 0);
    end
    chk("t5 ram[5]", ram[5], {8{16'(5 * 257)}});
    chk("t5 dc_rdata", dc_rdata, 0);
    run(0, 0, 26'd0, '0);
    chk("t5 ic_rdata", ic_rdata, K);
    ic_req1 = 1; ic_addr1 = 7;
    step();
    chk("t6 busy addr", mem_addr1, 7);
    chk("t6 busy ready", ic_ready1, 0);
    step();
    chk("t6 ready", ic_ready1, 1);
    chk("t6 rdata", ic_rdata1, K1);
    ic_req1 = 0;
    step();
    chk("t6 idle", {ic_ready1, mem_addr1}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
